// File: rtl/eci_vc_pkt_arbiter_pkg.sv
// ECI command definitions shared by the packetization layer.
// Word layout, dmask-to-length helpers and VC arbiter state encoding.
package eci_cmd_defs;

    localparam int ECI_WORD_WIDTH        = 64;
    localparam int ECI_PACKET_SIZE_WIDTH = 5;
    localparam int ECI_SCL_WIDTH         = 3;

    typedef logic [3:0] eci_dmask_t;

    typedef struct packed {
        logic [4:0]  opcode;
        eci_dmask_t  dmask;
        logic [54:0] rsvd;
    } eci_generic_cmd_t;

    typedef union packed {
        logic [ECI_WORD_WIDTH-1:0] raw;
        eci_generic_cmd_t          generic_cmd;
    } eci_word_t;

    typedef enum logic {
        IDLE,
        LOCK
    } eci_vc_arb_state_e;

    // Each set dmask bit is one sub-cache-line of four data words.
    function automatic logic [ECI_SCL_WIDTH-1:0] get_scl_from_dmask(
        input eci_dmask_t dm
    );
        logic [ECI_SCL_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + ECI_SCL_WIDTH'(dm[i]);
        end
        return n;
    endfunction

    function automatic logic [ECI_PACKET_SIZE_WIDTH-1:0]
        get_num_words_from_scl(input logic [ECI_SCL_WIDTH-1:0] scl);
        return {scl, 2'b00} + ECI_PACKET_SIZE_WIDTH'(1);
    endfunction

    function automatic eci_dmask_t get_dmask(input eci_word_t w);
        return w.generic_cmd.dmask;
    endfunction

endpackage

// File: rtl/eci_vc_pkt_arbiter_rr_pick.sv
// Combinational circular priority pick: first set request at or after ptr.
// Reusable by any ECI arbiter needing round-robin selection.
module eci_rr_pick_c #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        idx = '0;
        j   = 0;
        any = |req;
        // Walk backwards so the candidate closest to ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/eci_vc_pkt_arbiter.sv
// Packet-granular round-robin merge of N_VC ECI word streams onto one link.
// Define ECI_VC_ARB_OUT_REG_EN to add a 2-entry skid slice on the m_* side.
module eci_vc_pkt_arbiter
    import eci_cmd_defs::*;
#(
    parameter int N_VC     = 4,
    parameter int VC_IDX_W = $clog2(N_VC)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_VC*ECI_WORD_WIDTH-1:0] s_data,
    input  logic [N_VC-1:0]            s_valid,
    output logic [N_VC-1:0]            s_ready,
    output logic [ECI_WORD_WIDTH-1:0]  m_data,
    output logic [VC_IDX_W-1:0]        m_vc,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy
);

    eci_vc_arb_state_e state, state_n;
    logic [VC_IDX_W-1:0] grant, grant_n;
    logic [VC_IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [ECI_PACKET_SIZE_WIDTH-1:0] cnt, cnt_n;
    logic first_beat, first_beat_n;

    logic [VC_IDX_W-1:0] pick_idx;
    logic pick_any;
    logic [ECI_WORD_WIDTH-1:0] sel_data;
    logic [ECI_PACKET_SIZE_WIDTH-1:0] words;
    logic locked, in_valid, in_last, fwd_ready, beat;

    eci_rr_pick_c #(
        .N(N_VC),
        .W(VC_IDX_W)
    ) u_pick (
        .req(s_valid),
        .ptr(rr_ptr),
        .idx(pick_idx),
        .any(pick_any)
    );

    always_comb begin
        sel_data = s_data[int'(grant)*ECI_WORD_WIDTH +: ECI_WORD_WIDTH];
        words = get_num_words_from_scl(
            get_scl_from_dmask(get_dmask(sel_data)));
        if (words == '0) begin
            words = ECI_PACKET_SIZE_WIDTH'(1);
        end
        locked   = (state == LOCK);
        in_valid = locked & s_valid[grant];
        in_last  = locked & (first_beat ?
                   (words == ECI_PACKET_SIZE_WIDTH'(1)) :
                   (cnt == ECI_PACKET_SIZE_WIDTH'(1)));
        beat     = in_valid & fwd_ready;
    end

    always_comb begin
        s_ready = '0;
        if (locked) begin
            s_ready[grant] = fwd_ready;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        rr_ptr_n     = rr_ptr;
        cnt_n        = cnt;
        first_beat_n = first_beat;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n      = pick_idx;
                    first_beat_n = 1'b1;
                    state_n      = LOCK;
                end
            end
            LOCK: begin
                if (beat) begin
                    if (first_beat) begin
                        cnt_n        = words - ECI_PACKET_SIZE_WIDTH'(1);
                        first_beat_n = 1'b0;
                    end else begin
                        cnt_n = cnt - ECI_PACKET_SIZE_WIDTH'(1);
                    end
                    if (in_last) begin
                        state_n  = IDLE;
                        rr_ptr_n = (grant == VC_IDX_W'(N_VC - 1)) ?
                                   '0 : grant + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            first_beat <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            rr_ptr     <= rr_ptr_n;
            cnt        <= cnt_n;
            first_beat <= first_beat_n;
        end
    end

    assign busy = locked;

`ifdef ECI_VC_ARB_OUT_REG_EN
    logic [ECI_WORD_WIDTH-1:0] main_data, skid_data;
    logic [VC_IDX_W-1:0] main_vc, skid_vc;
    logic main_last, skid_last, main_valid, skid_valid;

    assign fwd_ready = ~skid_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_data  <= '0;
            main_vc    <= '0;
            main_last  <= 1'b0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_vc    <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (m_ready || !main_valid) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_vc    <= skid_vc;
                main_last  <= skid_last;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_data  <= sel_data;
                main_vc    <= grant;
                main_last  <= in_last;
                main_valid <= in_valid;
            end
        end else if (in_valid && !skid_valid) begin
            skid_data  <= sel_data;
            skid_vc    <= grant;
            skid_last  <= in_last;
            skid_valid <= 1'b1;
        end
    end

    assign m_data  = main_data;
    assign m_vc    = main_vc;
    assign m_last  = main_last;
    assign m_valid = main_valid;
`else
    assign fwd_ready = m_ready;
    assign m_data    = locked ? sel_data : '0;
    assign m_vc      = locked ? grant : '0;
    assign m_last    = in_last;
    assign m_valid   = in_valid;
`endif

endmodule
